// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the debounced key-to-LED decoder.
//   MODE_DIRECT / MODE_TOGGLE : LED register behaviour selectors
//   DEB_CYC_50MHZ             : 20 ms debounce window at a 50 MHz board clock
//   onehot(sel)               : one-hot decode of a select value, MAX_LED_W bits wide
package decoder_pkg;

    localparam int unsigned MODE_DIRECT   = 0;
    localparam int unsigned MODE_TOGGLE   = 1;
    localparam int unsigned DEB_CYC_50MHZ = 1000000;
    localparam int unsigned MAX_SEL_W     = 4;
    localparam int unsigned MAX_LED_W     = 16;

    // Callers truncate the result to their own LED bank width.
    function automatic logic [MAX_LED_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        onehot = MAX_LED_W'(1) << sel;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key synchroniser and debouncer.
//   sys_clk    : system clock
//   sys_rst    : asynchronous active-high reset (stable level returns to released)
//   key_raw    : raw key level, asynchronous to sys_clk
//   key_stable : debounced level, 1 = pressed regardless of KEY_POL
module key_debounce #(
    parameter int unsigned DEB_CYC = 4,
    parameter logic        KEY_POL = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_raw,
    output logic key_stable
);

    localparam int unsigned CNT_W = $clog2(DEB_CYC + 1);

    logic             key_norm_c;
    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    assign key_norm_c = KEY_POL ? key_raw : ~key_raw;

    // Two-stage synchroniser.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= key_norm_c;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DEB_CYC consecutive mismatched cycles.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt        <= '0;
            key_stable <= 1'b0;
        end else if (sync2 != key_stable) begin
            if (cnt == CNT_W'(DEB_CYC - 1)) begin
                key_stable <= sync2;
                cnt        <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/key_decoder_db.sv
// Debounced key-to-LED decoder: an enable key plus SEL_W select keys drive a
// one-hot LED bank, either following the held keys (DIRECT) or flipping the
// selected LED on each press (TOGGLE).
//   sys_clk : system clock
//   sys_rst : asynchronous active-high reset
//   key_en  : raw enable key
//   key_sel : raw select keys
//   led     : registered LED bank, 1 = lit
//   key_evt : one-cycle pulse per accepted press of key_en
module key_decoder_db
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DEB_CYC = DEB_CYC_50MHZ,
    parameter int unsigned MODE    = MODE_DIRECT,
    parameter logic        KEY_POL = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  key_en,
    input  logic [SEL_W-1:0]      key_sel,
    output logic [(1<<SEL_W)-1:0] led,
    output logic                  key_evt
);

    localparam int unsigned LED_W = 1 << SEL_W;

    logic [SEL_W:0]   key_raw_c;
    logic [SEL_W:0]   key_stable;
    logic             stable_en;
    logic [SEL_W-1:0] stable_sel;
    logic             stable_en_d;
    logic             en_rise_c;

    assign key_raw_c  = {key_en, key_sel};
    assign stable_en  = key_stable[SEL_W];
    assign stable_sel = key_stable[SEL_W-1:0];

    // One debouncer per key; enable is the top bit.
    for (genvar i = 0; i <= SEL_W; i++) begin : g_deb
        key_debounce #(
            .DEB_CYC (DEB_CYC),
            .KEY_POL (KEY_POL)
        ) u_deb (
            .sys_clk    (sys_clk),
            .sys_rst    (sys_rst),
            .key_raw    (key_raw_c[i]),
            .key_stable (key_stable[i])
        );
    end

    assign en_rise_c = stable_en & ~stable_en_d;

    // Press detector: pulse only on the debounced 0->1 transition.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            stable_en_d <= 1'b0;
            key_evt     <= 1'b0;
        end else begin
            stable_en_d <= stable_en;
            key_evt     <= en_rise_c;
        end
    end

    if (MODE == MODE_TOGGLE) begin : g_toggle
        // Flip the LED picked by the select level that is stable at the press.
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                led <= '0;
            end else if (en_rise_c) begin
                led[stable_sel] <= ~led[stable_sel];
            end
        end
    end else begin : g_direct
        logic [LED_W-1:0] led_dec_c;

        assign led_dec_c = LED_W'(onehot(MAX_SEL_W'(stable_sel)));

        // LED mirrors the debounced keys every cycle.
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                led <= '0;
            end else begin
                led <= stable_en ? led_dec_c : '0;
            end
        end
    end

endmodule
